// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC regular-mode bin encoder.
`timescale 1ns/1ps
package cabac_pkg;

   // Encoder control states
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RENORM     = 2'd1,
      ST_EMIT       = 2'd2,
      ST_FLUSH_TAIL = 2'd3
   } enc_state_e;

   localparam int RANGE_W = 9;
   localparam int LOW_W   = 10;

   // low thresholds are compared against the 11-bit internal low value
   localparam logic [LOW_W:0]     HALF       = 11'd256;
   localparam logic [LOW_W:0]     ONE        = 11'd512;
   localparam logic [RANGE_W-1:0] RANGE_INIT = 9'd510;

endpackage

// File: rtl/cabac_lps_calc.sv
// LPS sub-range from the probability state and the top four range bits.
// Shared between the encoder and the decoder.
`timescale 1ns/1ps
module cabac_lps_calc (
   input  logic [7:0] pstate_i,
   input  logic [3:0] range_idx_i,
   output logic [7:0] lps_o
);

   logic [6:0]  q_s;
   logic [10:0] prod_s;

   // q mirrors the probability index when the MPS is 1; product fits 11 bits (127*15)
   always_comb begin
      q_s    = pstate_i[7] ? ~pstate_i[6:0] : pstate_i[6:0];
      prod_s = {4'd0, q_s} * {7'd0, range_idx_i};
      lps_o  = prod_s[10:3] + 8'd4;
   end

endmodule

// File: rtl/cabac_bin_encoder.sv
// CABAC regular-mode arithmetic bin encoder with serial bit output.
// Optional feature macro: CABAC_ENC_STATS_EN adds bin_count/bit_count.
`timescale 1ns/1ps
module cabac_bin_encoder
   import cabac_pkg::*;
#(
   parameter int OUTST_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bin_valid,
   output logic       bin_ready,
   input  logic       bin_val,
   input  logic [7:0] pState,
   input  logic       flush_req,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_bit,
   output logic       flush_done,
   output logic       err_ovf
`ifdef CABAC_ENC_STATS_EN
   ,
   output logic [31:0] bin_count,
   output logic [31:0] bit_count
`endif
);

   localparam logic [OUTST_W-1:0] OUTST_MAX  = {OUTST_W{1'b1}};
   localparam logic [OUTST_W-1:0] OUTST_ZERO = {OUTST_W{1'b0}};
   localparam logic [OUTST_W-1:0] OUTST_ONE  = {{(OUTST_W-1){1'b0}}, 1'b1};

   enc_state_e         state_q, state_d;
   logic [RANGE_W-1:0] range_q, range_d;
   // low keeps one extra bit so that low + rMps never wraps before renorm
   logic [LOW_W:0]     low_q, low_d;
   logic [OUTST_W-1:0] outst_q, outst_d;
   logic               err_ovf_q, err_ovf_d;
   logic               flushing_q, flushing_d;
   logic               put_bit_q, put_bit_d;
   logic               out_valid_q, out_valid_d;
   logic               out_bit_q, out_bit_d;
   logic               flush_done_q, flush_done_d;
   logic [1:0]         tail_q, tail_d;

   logic [7:0]         lps_s;
   logic [RANGE_W-1:0] r_mps_s;
   logic [RANGE_W-1:0] flush_range_s;
   logic [RANGE_W-1:0] new_range_s;
   logic [LOW_W:0]     low_sub_s;
   logic               put_s;
   logic               put_val_s;

   cabac_lps_calc u_lps (
      .pstate_i    (pState),
      .range_idx_i (range_q[RANGE_W-1:RANGE_W-4]),
      .lps_o       (lps_s)
   );

   assign r_mps_s       = range_q - {1'b0, lps_s};
   assign flush_range_s = range_q - 9'd2;

   // Next-state, datapath and output-register update
   always_comb begin
      state_d      = state_q;
      range_d      = range_q;
      low_d        = low_q;
      outst_d      = outst_q;
      err_ovf_d    = err_ovf_q;
      flushing_d   = flushing_q;
      put_bit_d    = put_bit_q;
      out_valid_d  = out_valid_q;
      out_bit_d    = out_bit_q;
      flush_done_d = 1'b0;
      tail_d       = tail_q;
      new_range_s  = range_q;
      low_sub_s    = low_q;
      put_s        = 1'b0;
      put_val_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               // range - 2 is added to low, leaving a range of 2 to renormalize away
               low_d      = low_q + {2'b00, flush_range_s};
               range_d    = 9'd2;
               flushing_d = 1'b1;
               tail_d     = 2'd0;
               state_d    = ST_RENORM;
            end else if (bin_valid) begin
               if (bin_val == pState[7]) begin
                  new_range_s = r_mps_s;
               end else begin
                  low_d       = low_q + {2'b00, r_mps_s};
                  new_range_s = {1'b0, lps_s};
               end
               range_d = new_range_s;
               if (!new_range_s[RANGE_W-1]) begin
                  state_d = ST_RENORM;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RENORM: begin
            if (low_q < HALF) begin
               put_s     = 1'b1;
               put_val_s = 1'b0;
            end else if (low_q >= ONE) begin
               low_sub_s = low_q - ONE;
               put_s     = 1'b1;
               put_val_s = 1'b1;
            end else begin
               low_sub_s = low_q - HALF;
               if (outst_q == OUTST_MAX) begin
                  err_ovf_d = 1'b1;
               end else begin
                  outst_d = outst_q + OUTST_ONE;
               end
            end
            low_d   = {low_sub_s[LOW_W-1:0], 1'b0};
            range_d = {range_q[RANGE_W-2:0], 1'b0};
            if (put_s) begin
               out_valid_d = 1'b1;
               out_bit_d   = put_val_s;
               put_bit_d   = put_val_s;
               state_d     = ST_EMIT;
            end else if (range_q[RANGE_W-2]) begin
               state_d = flushing_q ? ST_FLUSH_TAIL : ST_IDLE;
            end else begin
               state_d = ST_RENORM;
            end
         end

         ST_EMIT: begin
            // put bit first, then one inverted copy per outstanding count
            if (out_ready) begin
               if (outst_q != OUTST_ZERO) begin
                  out_bit_d = ~put_bit_q;
                  outst_d   = outst_q - OUTST_ONE;
               end else begin
                  out_valid_d = 1'b0;
                  if (!range_q[RANGE_W-1]) begin
                     state_d = ST_RENORM;
                  end else if (flushing_q) begin
                     state_d = ST_FLUSH_TAIL;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else begin
               state_d = ST_EMIT;
            end
         end

         ST_FLUSH_TAIL: begin
            case (tail_q)
               2'd0: begin
                  out_valid_d = 1'b1;
                  out_bit_d   = low_q[LOW_W-1];
                  put_bit_d   = low_q[LOW_W-1];
                  tail_d      = 2'd1;
                  state_d     = ST_EMIT;
               end
               2'd1: begin
                  out_valid_d = 1'b1;
                  out_bit_d   = low_q[LOW_W-2];
                  tail_d      = 2'd2;
               end
               2'd2: begin
                  if (out_ready) begin
                     out_bit_d = 1'b1;
                     tail_d    = 2'd3;
                  end else begin
                     tail_d = 2'd2;
                  end
               end
               2'd3: begin
                  if (out_ready) begin
                     out_valid_d  = 1'b0;
                     flush_done_d = 1'b1;
                     range_d      = RANGE_INIT;
                     low_d        = 11'd0;
                     outst_d      = OUTST_ZERO;
                     flushing_d   = 1'b0;
                     tail_d       = 2'd0;
                     state_d      = ST_IDLE;
                  end else begin
                     tail_d = 2'd3;
                  end
               end
               default: begin
                  tail_d = 2'd0;
               end
            endcase
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         range_q      <= RANGE_INIT;
         low_q        <= 11'd0;
         outst_q      <= OUTST_ZERO;
         err_ovf_q    <= 1'b0;
         flushing_q   <= 1'b0;
         put_bit_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_bit_q    <= 1'b0;
         flush_done_q <= 1'b0;
         tail_q       <= 2'd0;
      end else begin
         state_q      <= state_d;
         range_q      <= range_d;
         low_q        <= low_d;
         outst_q      <= outst_d;
         err_ovf_q    <= err_ovf_d;
         flushing_q   <= flushing_d;
         put_bit_q    <= put_bit_d;
         out_valid_q  <= out_valid_d;
         out_bit_q    <= out_bit_d;
         flush_done_q <= flush_done_d;
         tail_q       <= tail_d;
      end
   end

   assign bin_ready  = (state_q == ST_IDLE);
   assign out_valid  = out_valid_q;
   assign out_bit    = out_bit_q;
   assign flush_done = flush_done_q;
   assign err_ovf    = err_ovf_q;

`ifdef CABAC_ENC_STATS_EN
   logic [31:0] bin_count_q;
   logic [31:0] bit_count_q;
   logic        bin_acc_s;

   assign bin_acc_s = (state_q == ST_IDLE) && bin_valid && !flush_req;

   // Accepted-bin and accepted-bit counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_count_q <= 32'd0;
         bit_count_q <= 32'd0;
      end else begin
         bin_count_q <= bin_count_q + {31'd0, bin_acc_s};
         bit_count_q <= bit_count_q + {31'd0, (out_valid_q & out_ready)};
      end
   end

   assign bin_count = bin_count_q;
   assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_cabac_bin_encoder.sv
// Directed self-checking bench for cabac_bin_encoder.
`timescale 1ns/1ps
module tb_cabac_bin_encoder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       bin_valid, bin_val, flush_req, out_ready;
   logic [7:0] pstate;
   logic       bin_ready, out_valid, out_bit, flush_done, err_ovf;

   logic       b_bin_valid, b_bin_val, b_flush_req, b_out_ready;
   logic [7:0] b_pstate;
   logic       b_bin_ready, b_out_valid, b_out_bit, b_flush_done, b_err_ovf;

`ifdef CABAC_ENC_STATS_EN
   logic [31:0] a_bin_count, a_bit_count, b_bin_count, b_bit_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] bits;
   int          got;
   bit          ok;

   always #5 clk = ~clk;

   cabac_bin_encoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bin_valid  (bin_valid),
      .bin_ready  (bin_ready),
      .bin_val    (bin_val),
      .pState     (pstate),
      .flush_req  (flush_req),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bit    (out_bit),
      .flush_done (flush_done),
      .err_ovf    (err_ovf)
`ifdef CABAC_ENC_STATS_EN
      ,
      .bin_count  (a_bin_count),
      .bit_count  (a_bit_count)
`endif
   );

   cabac_bin_encoder #(.OUTST_W(2)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bin_valid  (b_bin_valid),
      .bin_ready  (b_bin_ready),
      .bin_val    (b_bin_val),
      .pState     (b_pstate),
      .flush_req  (b_flush_req),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .out_bit    (b_out_bit),
      .flush_done (b_flush_done),
      .err_ovf    (b_err_ovf)
`ifdef CABAC_ENC_STATS_EN
      ,
      .bin_count  (b_bin_count),
      .bit_count  (b_bit_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Record accepted bits MSB-first; each recorded bit is taken at the following edge
   task automatic collect(input bit sel, input int n, input int budget,
                          output logic [15:0] b, output int g);
      b = 16'd0;
      g = 0;
      for (int c = 0; c < budget && g < n; c++) begin
         if (sel ? (b_out_valid && b_out_ready) : (out_valid && out_ready)) begin
            b = {b[14:0], (sel ? b_out_bit : out_bit)};
            g++;
         end
         step();
      end
   endtask

   task automatic wait_ready(input int budget, output bit r);
      r = 1'b0;
      for (int c = 0; c < budget && !r; c++) begin
         if (bin_ready) r = 1'b1;
         else step();
      end
   endtask

   initial begin
      bin_valid = 1'b0; bin_val = 1'b0; flush_req = 1'b0; out_ready = 1'b1; pstate = 8'h00;
      b_bin_valid = 1'b0; b_bin_val = 1'b0; b_flush_req = 1'b0; b_out_ready = 1'b1;
      b_pstate = 8'h00;
      rst_n = 1'b0;

      // Reset state
      do_reset();
      chk("rst_bin_ready", {31'd0, bin_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_bit", {31'd0, out_bit}, 32'd0);
      chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
      chk("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
      chk("rst_range", {23'd0, dut.range_q}, 32'd510);
      chk("rst_low", {21'd0, dut.low_q}, 32'd0);

      // MPS without renorm: lps 242, range 268
      bin_valid = 1'b1; pstate = 8'h80; bin_val = 1'b1;
      step();
      bin_valid = 1'b0;
      chk("mps_range", {23'd0, dut.range_q}, 32'd268);
      chk("mps_low", {21'd0, dut.low_q}, 32'd0);
      chk("mps_ready", {31'd0, bin_ready}, 32'd1);
      chk("mps_no_out", {31'd0, out_valid}, 32'd0);

      // LPS then MPS from reset
      do_reset();
      bin_valid = 1'b1; pstate = 8'h80; bin_val = 1'b0;
      step();
      bin_valid = 1'b0;
      chk("lps_busy", {31'd0, bin_ready}, 32'd0);
      wait_ready(20, ok);
      chk("lps_ready_timeout", {31'd0, ok}, 32'd1);
      chk("lps_range", {23'd0, dut.range_q}, 32'd484);
      chk("lps_low", {21'd0, dut.low_q}, 32'd24);
      chk("lps_outst", {16'd0, dut.outst_q}, 32'd1);
      chk("lps_no_out", {31'd0, out_valid}, 32'd0);
      bin_valid = 1'b1; pstate = 8'h80; bin_val = 1'b1;
      step();
      bin_valid = 1'b0;
      collect(1'b0, 2, 20, bits, got);
      chk("lm_bit_count", got, 32'd2);
      chk("lm_bits", {30'd0, bits[1:0]}, 32'd1);
      wait_ready(20, ok);
      chk("lm_ready_timeout", {31'd0, ok}, 32'd1);
      chk("lm_range", {23'd0, dut.range_q}, 32'd484);
      chk("lm_low", {21'd0, dut.low_q}, 32'd48);
      chk("lm_outst", {16'd0, dut.outst_q}, 32'd0);
      chk("lm_no_extra", {31'd0, out_valid}, 32'd0);

      // Backpressure on the same sequence
      do_reset();
      bin_valid = 1'b1; pstate = 8'h80; bin_val = 1'b0;
      step();
      bin_valid = 1'b0;
      wait_ready(20, ok);
      out_ready = 1'b0;
      bin_valid = 1'b1; pstate = 8'h80; bin_val = 1'b1;
      step();
      bin_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
         chk("bp_bit_stable", {31'd0, out_bit}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      collect(1'b0, 2, 20, bits, got);
      chk("bp_bit_count", got, 32'd2);
      chk("bp_bits", {30'd0, bits[1:0]}, 32'd1);

      // Flush from reset, with a competing bin that must not be consumed
      do_reset();
      flush_req = 1'b1; bin_valid = 1'b1; pstate = 8'h80; bin_val = 1'b0;
      step();
      flush_req = 1'b0; bin_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("fl_outst7", {16'd0, dut.outst_q}, 32'd7);
      chk("fl_no_out_yet", {31'd0, out_valid}, 32'd0);
      collect(1'b0, 10, 60, bits, got);
      chk("fl_bit_count", got, 32'd10);
      chk("fl_bits", {22'd0, bits[9:0]}, 32'h1FD);
      chk("fl_done_pulse", {31'd0, flush_done}, 32'd1);
      chk("fl_ready", {31'd0, bin_ready}, 32'd1);
      step();
      chk("fl_done_low", {31'd0, flush_done}, 32'd0);
      chk("fl_range", {23'd0, dut.range_q}, 32'd510);
      chk("fl_low", {21'd0, dut.low_q}, 32'd0);
      chk("fl_no_extra", {31'd0, out_valid}, 32'd0);

      // Outstanding overflow with a 2-bit counter
      do_reset();
      b_flush_req = 1'b1;
      step();
      b_flush_req = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("ov_outst_sat", {30'd0, dut2.outst_q}, 32'd3);
      chk("ov_err", {31'd0, b_err_ovf}, 32'd1);
      collect(1'b1, 6, 60, bits, got);
      chk("ov_bit_count", got, 32'd6);
      chk("ov_bits", {26'd0, bits[5:0]}, 32'h1D);
      chk("ov_done_pulse", {31'd0, b_flush_done}, 32'd1);
      step();
      chk("ov_err_sticky", {31'd0, b_err_ovf}, 32'd1);
      do_reset();
      chk("ov_err_cleared", {31'd0, b_err_ovf}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cabac_bin_encoder.md
# cabac_bin_encoder

Sequential VVC CABAC regular-mode arithmetic encoder, the transmit-side counterpart of the team's regular bin decoder. It accepts one context-coded bin per handshake together with its 8-bit probability state. It updates the 9-bit range and 10-bit low registers and renormalizes one bit per cycle, resolving carries with an outstanding-bit counter. It emits the coded bitstream serially under ready/valid backpressure, and a flush request terminates the arithmetic codeword.

## Interface
- OUTST_W, 16, width of outstanding-bit counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bin_valid  in  1  bin presented
- bin_ready  out  1  encoder can accept bin or flush
- bin_val  in  1  bin to encode
- pState  in  8  probability state; bit 7 = MPS, bits 6:0 = probability index
- flush_req  in  1  terminate codeword (accepted with bin_ready; has priority over bin_valid)
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accepts out_bit
- out_bit  out  1  coded bit, MSB-first
- flush_done  out  1  one-cycle pulse after the last flush bit is accepted
- err_ovf  out  1  sticky: outstanding counter saturated
- bin_count, bit_count  out  32 each  (only with CABAC_ENC_STATS_EN)

## Operation
- LPS range: q = pState[7] ? ~pState[6:0] : pState[6:0]; lps = ((q × range[8:5]) >> 3) + 4. Result is 8 bits, max 242.
- Bin accept (bin_valid & bin_ready & !flush_req):
  - rMps = range − lps.
  - bin_val == pState[7]: range = rMps.
  - Otherwise: low = low + rMps, range = lps.
- Flush accept: range = range − 2; low = low + range; range = 2. Then normal renorm, then one put of low[9], then two raw bits low[8] and then 1.
- FSM states and transitions:
  - IDLE: bin_ready = 1.
    - After an accept, go to RENORM if the new range < 256.
    - Otherwise stay in IDLE. MPS without renorm gives 1 bin/cycle.
  - RENORM: one iteration per cycle while range < 256.
    - low < 256: put 0.
    - low ≥ 512: low −= 512, put 1.
    - Else: low −= 256, outstanding++.
    - Then low <<= 1, range <<= 1.
    - A put transfers to EMIT.
  - EMIT: drive the put bit, then `outstanding` copies of its inverse; each bit is held until out_ready. Return to RENORM if range < 256, else to IDLE or FLUSH_TAIL.
  - FLUSH_TAIL: after renorm completes, put low[9] through EMIT, then emit the two raw bits (no outstanding), pulse flush_done, then go to IDLE. Encoder state resets to range = 510, low = 0, outstanding = 0.
- Outstanding counter saturates at 2^OUTST_W − 1. A further increment is dropped and err_ovf is set; only rst_n clears err_ovf.
- Arithmetic: low carried in 11 bits internally, so low + rMps cannot wrap; the 10-bit register is reloaded after renorm subtraction.

## Timing
- Reset values: range = 510, low = 0, outstanding = 0, state = IDLE, bin_ready = 1, out_valid = 0, out_bit = 0, flush_done = 0, err_ovf = 0, counters = 0.
- Registers update on the edge ending the accept cycle.
- bin_ready is low in RENORM, EMIT and FLUSH_TAIL.
- Each renorm iteration without a put takes 1 cycle.
- Each emitted bit takes ≥ 1 cycle: out_valid is registered; out_bit is stable while out_valid & !out_ready.
- Reset asserted mid-operation aborts immediately to reset values; a partial bitstream is discarded.
- flush_req asserted with bin_valid: flush accepted, the bin is not consumed.

## Configuration
- CABAC_ENC_STATS_EN defined:
  - bin_count increments per accepted bin.
  - bit_count increments per accepted out_bit.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent.

## Structure
- Package cabac_pkg:
  - FSM state enum (IDLE, RENORM, EMIT, FLUSH_TAIL).
  - RANGE_W = 9, LOW_W = 10.
  - HALF = 256, ONE = 512, RANGE_INIT = 510.
- Sub-module cabac_lps_calc: combinational lps from pState and range; shared with the decoder side.

## Test plan
- Reset: release rst_n → range 510, low 0, bin_ready 1, out_valid 0, err_ovf 0.
- MPS without renorm: pState 0x80, bin 1 → lps 242, range 268, low 0, no output, bin_ready high next cycle.
- LPS then MPS, starting from reset:
  - pState 0x80, bin 0 → low 24, range 484, outstanding 1, no bits.
  - Then pState 0x80, bin 1 → range 242 → renorm emits 0,1, then low 48, range 484, outstanding 0.
- Backpressure: repeat the previous case with out_ready low for 5 cycles → out_valid held, out_bit = 0 stable. After release, bits 0 then 1.
- Flush from reset:
  - Flush runs 7 renorm iterations, outstanding reaching 7.
  - Stream is 0, 1111111, 0, 1 (10 bits), then a flush_done pulse, then range 510.
- Overflow: OUTST_W = 2, flush from reset → counter saturates at 3 and err_ovf = 1, sticky until rst_n.
